motoro3_hall_decoder: RTL
=========================

Name: motoro3_hall_decoder

Overview:
Receive-side counterpart of the open-loop commutation step generator. Samples the three motor Hall sensors, synchronises and debounces them, and decodes them to the same 1..6 commutation step numbering the generator drives. Reports direction, the measured period between steps, stall and invalid-code fault. Feeds closed-loop commutation and speed control.

Parameters:
DEBOUNCE_CYC, 16, consecutive stable clk cycles a synchronised Hall code needs before it is accepted (1.6 us at 10 MHz); legal range 1..255.
STALL_CYC, 10_000_000, cycles without an accepted step before stall is declared (1 s at 10 MHz); must be < 2^PER_W.
PER_W, 25, width of the period counter and the hPeriod output.

Ports:
clk  input  1  10 MHz system clock; all registers update on the falling edge.
nRst  input  1  reset, asynchronous, active-low.
hA / hB / hC  input  1 each  raw Hall inputs, asynchronous.
en  input  1  decoder enable; low forces IDLE.
hStep  output  4  0 = idle or invalid; 1..6 = decoded step.
hStepPulse  output  1  one-cycle pulse when hStep takes a new non-zero value.
hDir  output  1  1 = forward (step+1), 0 = reverse.
hPeriod  output  PER_W  clk cycles between the last two adjacent steps.
hPeriodVld  output  1  one-cycle pulse when hPeriod is updated.
hStall  output  1  level; high in the STALL state.
hFault  output  1  level; high in the FAULT state.
hRevCnt  output  32  signed electrical revolution count; present only with the optional feature.

Behaviour:
- Reset values: all outputs 0; sync flops 0; filtered code 3'b000; state IDLE.
- Synchroniser: two flops per input. Debounce: a candidate code is accepted once it has been identical for DEBOUNCE_CYC consecutive cycles. Any difference reloads the candidate and clears the stability count.
- Latency: a clean input change appears on hStep exactly DEBOUNCE_CYC+3 falling edges later.
- Decode table, {hA,hB,hC} -> step: 101->1, 100->2, 110->3, 010->4, 011->5, 001->6. 000 and 111 are invalid.
- Event: the accepted code differs from the previously accepted code.
- The period counter is cleared on every event. It increments each cycle in RUN and saturates at all-ones.
- State machine (IDLE, RUN, STALL, FAULT):
  - IDLE: hStep=0. On a valid event: hStep<=decoded step, hStepPulse, go to RUN. No hPeriodVld on the first edge.
  - RUN, adjacent forward event (new = old mod 6 + 1): hDir<=1, hPeriod<=cnt+1 (saturating), hPeriodVld.
  - RUN, adjacent reverse event: hDir<=0, with the same period update.
  - RUN, non-adjacent valid event (skipped step): hStep updated, hDir held, no hPeriodVld, counter restarted.
  - RUN, counter reaches STALL_CYC: go to STALL. hStep, hDir and hPeriod are held.
  - STALL: on any valid event: go to RUN, update hStep/hDir, no hPeriodVld.
  - Invalid code accepted in any state: go to FAULT with hStep=0.
  - FAULT: on a valid event: go to RUN as from IDLE.
- en low: synchronous return to IDLE, all outputs to reset values. Sync and debounce keep running.
- Simultaneous events:
  - en low beats event.
  - Event beats stall threshold.
  - Invalid code beats everything except en.
- The reset value of the filtered code is 000, but this is not treated as an accepted invalid event; only a later accepted 000/111 faults.

Optional Feature:
Macro HALL_REVCNT_EN.
- Defined: hRevCnt is a 32-bit signed counter. +1 on an adjacent forward 6->1 event, -1 on an adjacent reverse 1->6 event, wraps two's-complement. Cleared by reset or en low.
- Undefined: the hRevCnt port and its counter are absent.

Decomposition:
- Shared package motoro3_pkg:
  - step constants STEP_IDLE=0, STEP_1..STEP_6.
  - decoder state enum.
  - functions hall2step, step_next, step_prev.
  - the same step constants are to be used by the step generator.
- One sub-module, motoro3_hall_debounce: 3-bit two-flop synchroniser plus debounce filter. Outputs the accepted code and a one-cycle accept strobe.

Test Plan:
1. Reset, en=1, DEBOUNCE_CYC=16; drive 101,100,110,010,011,001,101, each held 1000 cycles -> hStep 1..6,1; hDir=1; hPeriodVld pulses 6 times, each hPeriod=1000; the first edge gives no period.
2. Drive the reverse sequence 001,011,010 at 500 cycles each -> hDir=0, hPeriod=500.
3. In RUN, glitch hB for 10 cycles -> hStep, hStepPulse and period unchanged; a 16-cycle stable change -> accepted after 19 edges.
4. Drive 111 for 100 cycles -> hFault=1, hStep=0; then 101 -> RUN, hStep=1, hFault=0, no hPeriodVld.
5. STALL_CYC=5000; hold a code -> hStall rises 5000 cycles after the last event; the next adjacent code -> hStall=0, no hPeriodVld. Drop en mid-RUN -> all outputs 0 on the next edge.
6. With HALL_REVCNT_EN: two forward revolutions -> hRevCnt=2; then one reverse revolution -> hRevCnt=1.

Source files
------------

// File: rtl/motoro3_pkg.sv
// motoro3_pkg: step numbering, decoder state and Hall/step helpers shared by the commutation blocks
package motoro3_pkg;
  localparam logic [3:0] STEP_IDLE = 4'd0;
  localparam logic [3:0] STEP_1 = 4'd1;
  localparam logic [3:0] STEP_2 = 4'd2;
  localparam logic [3:0] STEP_3 = 4'd3;
  localparam logic [3:0] STEP_4 = 4'd4;
  localparam logic [3:0] STEP_5 = 4'd5;
  localparam logic [3:0] STEP_6 = 4'd6;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STALL, ST_FAULT} hall_state_e;
  function automatic logic [3:0] hall2step(input logic [2:0] h);
    case (h)
      3'b101: return STEP_1;
      3'b100: return STEP_2;
      3'b110: return STEP_3;
      3'b010: return STEP_4;
      3'b011: return STEP_5;
      3'b001: return STEP_6;
      default: return STEP_IDLE;
    endcase
  endfunction
  function automatic logic [3:0] step_next(input logic [3:0] s);
    return s == STEP_6 ? STEP_1 : s + 4'd1;
  endfunction
  function automatic logic [3:0] step_prev(input logic [3:0] s);
    return s == STEP_1 ? STEP_6 : s - 4'd1;
  endfunction
endpackage

// File: rtl/motoro3_hall_debounce.sv
// motoro3_hall_debounce: two-flop synchroniser and stability filter for the 3-bit Hall code
module motoro3_hall_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [2:0] hall,
  output logic [2:0] code,
  output logic       acc
);
  logic [2:0] s1, s2, cand;
  logic [7:0] cnt, cnt_nxt;
  logic       hit;
  // cnt is the number of cycles s2 has held the current candidate, this one included
  assign cnt_nxt = s2 != cand ? 8'd1 : (cnt == 8'hff ? cnt : cnt + 8'd1);
  assign hit = cnt_nxt == 8'(DEBOUNCE_CYC);
  always_ff @(negedge clk or negedge nRst)
    if (!nRst) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
      code <= '0;
      acc  <= 1'b0;
    end else begin
      s1   <= hall;
      s2   <= s1;
      cand <= s2;
      cnt  <= cnt_nxt;
      acc  <= hit && s2 != code;
      if (hit) code <= s2;
    end
endmodule

// File: rtl/motoro3_hall_decoder.sv
// motoro3_hall_decoder: Hall sensor decode to steps 1..6 with direction, period, stall and fault;
// defining HALL_REVCNT_EN adds the signed electrical revolution counter hRevCnt.
module motoro3_hall_decoder
  import motoro3_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int STALL_CYC    = 10_000_000,
  parameter int PER_W        = 25
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               hA,
  input  logic               hB,
  input  logic               hC,
  input  logic               en,
  output logic [3:0]         hStep,
  output logic               hStepPulse,
  output logic               hDir,
  output logic [PER_W-1:0]   hPeriod,
  output logic               hPeriodVld,
`ifdef HALL_REVCNT_EN
  output logic signed [31:0] hRevCnt,
`endif
  output logic               hStall,
  output logic               hFault
);
  localparam logic [PER_W-1:0] STALL_LIM = PER_W'(STALL_CYC);
  hall_state_e      state;
  logic [2:0]       code;
  logic             acc, valid, fwd, rev, adj;
  logic [3:0]       new_step;
  logic [PER_W-1:0] cnt, cnt_inc;
  motoro3_hall_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk (clk),
    .nRst(nRst),
    .hall({hA, hB, hC}),
    .code(code),
    .acc (acc)
  );
  assign new_step = hall2step(code);
  assign valid = new_step != STEP_IDLE;
  assign fwd = new_step == step_next(hStep);
  assign rev = new_step == step_prev(hStep);
  // adjacency only means something once a step is held
  assign adj = (state == ST_RUN || state == ST_STALL) && (fwd || rev);
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_ff @(negedge clk or negedge nRst)
    if (!nRst) begin
      state      <= ST_IDLE;
      hStep      <= STEP_IDLE;
      hStepPulse <= 1'b0;
      hDir       <= 1'b0;
      hPeriod    <= '0;
      hPeriodVld <= 1'b0;
      hStall     <= 1'b0;
      hFault     <= 1'b0;
      cnt        <= '0;
`ifdef HALL_REVCNT_EN
      hRevCnt    <= '0;
`endif
    end else begin
      hStepPulse <= 1'b0;
      hPeriodVld <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        hStep   <= STEP_IDLE;
        hDir    <= 1'b0;
        hPeriod <= '0;
        hStall  <= 1'b0;
        hFault  <= 1'b0;
        cnt     <= '0;
`ifdef HALL_REVCNT_EN
        hRevCnt <= '0;
`endif
      end else if (acc && !valid) begin
        state  <= ST_FAULT;
        hStep  <= STEP_IDLE;
        hStall <= 1'b0;
        hFault <= 1'b1;
        cnt    <= '0;
      end else if (acc) begin
        state      <= ST_RUN;
        hStep      <= new_step;
        hStepPulse <= 1'b1;
        hStall     <= 1'b0;
        hFault     <= 1'b0;
        cnt        <= '0;
        if (adj) hDir <= fwd;
        if (adj && state == ST_RUN) begin
          hPeriod    <= cnt_inc;
          hPeriodVld <= 1'b1;
        end
`ifdef HALL_REVCNT_EN
        if (adj && fwd && new_step == STEP_1) hRevCnt <= hRevCnt + 32'sd1;
        else if (adj && rev && new_step == STEP_6) hRevCnt <= hRevCnt - 32'sd1;
`endif
      end else if (state == ST_RUN) begin
        cnt <= cnt_inc;
        if (cnt_inc >= STALL_LIM) begin
          state  <= ST_STALL;
          hStall <= 1'b1;
        end
      end
    end
endmodule
